// File: rtl/mdl_bdlcntr_pkg.sv
// Shared definitions for the bubble data length counter family:
// sequencer states, ROT20 slot positions and default page length width.
package mdl_bdlcntr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAIN,
    ST_SUPB,
    ST_DONE
  } bdl_state_e;

  localparam int unsigned SLOT_A = 3;
  localparam int unsigned SLOT_B = 8;
  localparam int unsigned SLOT_C = 13;
  localparam int unsigned SLOT_D = 18;

  localparam int PGLEN_W_DEF = 10;

endpackage

// File: rtl/mdl_rot20_slotdec.sv
// ROT20 data slot decode: slots 3/8 always, plus 13/18 in 4-bit mode.
module mdl_rot20_slotdec
  import mdl_bdlcntr_pkg::*;
(
  input  logic [19:0] rot20_n,
  input  logic        ben4_n,
  output logic        slot
);

  logic unused_rot20;

  always_comb begin
    slot = ~(rot20_n[SLOT_A] & rot20_n[SLOT_B]);
    if (!ben4_n) begin
      slot = ~(rot20_n[SLOT_A] & rot20_n[SLOT_B] & rot20_n[SLOT_C] & rot20_n[SLOT_D]);
    end
  end

  // Only four slot positions matter; the remaining bits are deliberately ignored.
  assign unused_rot20 = &rot20_n;

endmodule

// File: rtl/mdl_bdlcntr.sv
// Main bubble data length counter: counts a page of data bits, then hands off
// to the supplementary stage. Optional SUPB timeout: define BDLCNTR_TIMEOUT_EN.
module mdl_bdlcntr
  import mdl_bdlcntr_pkg::*;
#(
  parameter int PGLEN_W = PGLEN_W_DEF
`ifdef BDLCNTR_TIMEOUT_EN
  ,
  parameter int SUPB_TIMEOUT = 64
`endif
) (
  input  logic               i_MCLK,
  input  logic               i_MRST_n,
  input  logic               i_CLK2M_PCEN_n,
  input  logic [19:0]        i_ROT20_n,
  input  logic               i_4BEN_n,
  input  logic               i_SYS_RUN_FLAG,
  input  logic               i_PGLEN_LD,
  input  logic [PGLEN_W-1:0] i_PGLEN,
  input  logic               i_BIT_XFER,
  input  logic               i_SUPBD_END_n,
  output logic               o_BDLCNTR_ACT_n,
  output logic               o_SUPBD_START_n,
  output logic               o_PAGE_DONE_n,
  output logic [PGLEN_W-1:0] o_BDLCNTR_VAL
`ifdef BDLCNTR_TIMEOUT_EN
  ,
  output logic               o_BDLCNTR_TMO_n
`endif
);

  bdl_state_e         state;
  logic [PGLEN_W-1:0] cntr;
  logic               act_n;
  logic               start_n;
  logic               done_n;
  logic               slot;
  logic               cnt;

`ifdef BDLCNTR_TIMEOUT_EN
  localparam logic [6:0] TMO_LAST = 7'(SUPB_TIMEOUT - 1);
  logic [6:0] tmo_cnt;
  logic       tmo_n;
`endif

  mdl_rot20_slotdec u_slotdec (
    .rot20_n (i_ROT20_n),
    .ben4_n  (i_4BEN_n),
    .slot    (slot)
  );

  assign cnt = slot & i_BIT_XFER;

  always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state   <= ST_IDLE;
      cntr    <= '0;
      act_n   <= 1'b1;
      start_n <= 1'b1;
      done_n  <= 1'b1;
`ifdef BDLCNTR_TIMEOUT_EN
      tmo_cnt <= '0;
      tmo_n   <= 1'b1;
`endif
    end else if (!i_CLK2M_PCEN_n) begin
      start_n <= 1'b1;
      done_n  <= 1'b1;
`ifdef BDLCNTR_TIMEOUT_EN
      tmo_n   <= 1'b1;
`endif
      if (!i_SYS_RUN_FLAG) begin
        state <= ST_IDLE;
        cntr  <= '0;
        act_n <= 1'b1;
`ifdef BDLCNTR_TIMEOUT_EN
        tmo_cnt <= '0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_PGLEN_LD) begin
              if (i_PGLEN != '0) begin
                cntr  <= i_PGLEN;
                act_n <= 1'b0;
                state <= ST_MAIN;
              end else begin
                start_n <= 1'b0;
                state   <= ST_SUPB;
`ifdef BDLCNTR_TIMEOUT_EN
                tmo_cnt <= '0;
`endif
              end
            end
          end
          ST_MAIN: begin
            if (cnt && cntr != '0) begin
              cntr <= cntr - PGLEN_W'(1);
              if (cntr == PGLEN_W'(1)) begin
                act_n   <= 1'b1;
                start_n <= 1'b0;
                state   <= ST_SUPB;
`ifdef BDLCNTR_TIMEOUT_EN
                tmo_cnt <= '0;
`endif
              end
            end
          end
          ST_SUPB: begin
            // start_n still low marks the handoff period, where END_n is not yet trusted
            if (start_n && !i_SUPBD_END_n) begin
              done_n <= 1'b0;
              state  <= ST_DONE;
            end
`ifdef BDLCNTR_TIMEOUT_EN
            else if (slot) begin
              if (tmo_cnt == TMO_LAST) begin
                tmo_n   <= 1'b0;
                tmo_cnt <= '0;
                state   <= ST_IDLE;
              end else begin
                tmo_cnt <= tmo_cnt + 7'd1;
              end
            end
`endif
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_BDLCNTR_ACT_n = act_n;
  assign o_SUPBD_START_n = start_n;
  assign o_PAGE_DONE_n   = done_n;
  assign o_BDLCNTR_VAL   = cntr;
`ifdef BDLCNTR_TIMEOUT_EN
  assign o_BDLCNTR_TMO_n = tmo_n;
`endif

endmodule

// File: tb/tb_mdl_bdlcntr.sv
// Self-checking bench for mdl_bdlcntr: vector table, hand-written corner
// sequences and randomized pages checked against a slot-counting model.
module tb_mdl_bdlcntr;

  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pcen_n;
  logic [19:0]   rot20_n;
  logic          ben4_n;
  logic          sysrun;
  logic          ld;
  logic [PW-1:0] pglen;
  logic          xfer;
  logic          end_n;
  logic          act_n;
  logic          start_n;
  logic          done_n;
  logic [PW-1:0] val;
`ifdef BDLCNTR_TIMEOUT_EN
  logic          tmo_n;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned rot_pos = 0;

  typedef struct {
    logic [PW-1:0] pglen;
    logic          ben4_n;
    int unsigned   exp_start;
  } vec_t;

  vec_t vecs[7];

  mdl_bdlcntr #(
    .PGLEN_W(PW)
`ifdef BDLCNTR_TIMEOUT_EN
    ,
    .SUPB_TIMEOUT(4)
`endif
  ) dut (
    .i_MCLK          (clk),
    .i_MRST_n        (rst_n),
    .i_CLK2M_PCEN_n  (pcen_n),
    .i_ROT20_n       (rot20_n),
    .i_4BEN_n        (ben4_n),
    .i_SYS_RUN_FLAG  (sysrun),
    .i_PGLEN_LD      (ld),
    .i_PGLEN         (pglen),
    .i_BIT_XFER      (xfer),
    .i_SUPBD_END_n   (end_n),
    .o_BDLCNTR_ACT_n (act_n),
    .o_SUPBD_START_n (start_n),
    .o_PAGE_DONE_n   (done_n),
    .o_BDLCNTR_VAL   (val)
`ifdef BDLCNTR_TIMEOUT_EN
    ,
    .o_BDLCNTR_TMO_n (tmo_n)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One enable edge followed by 0..2 disabled edges; ROT20 advances per enable.
  task automatic en_cycle();
    rot20_n = ~(20'd1 << rot_pos);
    pcen_n = 1'b0;
    @(posedge clk);
    #1;
    pcen_n = 1'b1;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    rot_pos = (rot_pos == 19) ? 0 : rot_pos + 1;
  endtask

  function automatic bit is_slot(input int unsigned pos, input logic b4n);
    return (pos == 3 || pos == 8 || (!b4n && (pos == 13 || pos == 18)));
  endfunction

  task automatic run_vec(input vec_t v);
    int unsigned s;
    int unsigned act_bad;
    bit seen;
    rot_pos = 0;
    ben4_n = v.ben4_n;
    xfer = 1'b1;
    pglen = v.pglen;
    ld = 1'b1;
    en_cycle();
    ld = 1'b0;
    chk("vec load act_n", 32'(act_n), 32'd0);
    chk("vec load val", 32'(val), 32'(v.pglen));
    seen = 0;
    s = 0;
    act_bad = 0;
    for (int unsigned c = 1; c <= 400 && !seen; c++) begin
      en_cycle();
      if (start_n === 1'b0) begin
        seen = 1;
        s = c;
      end else if (act_n !== 1'b0) begin
        act_bad++;
      end
    end
    chk("vec start cycle", s, v.exp_start);
    chk("vec act_n gaps", act_bad, 32'd0);
    chk("vec act_n at start", 32'(act_n), 32'd1);
    end_n = 1'b0;
    en_cycle();
    chk("vec end ignored", 32'(done_n), 32'd1);
    chk("vec start one period", 32'(start_n), 32'd1);
    en_cycle();
    chk("vec page done", 32'(done_n), 32'd0);
    end_n = 1'b1;
    en_cycle();
    chk("vec page done one period", 32'(done_n), 32'd1);
  endtask

  initial begin
    vecs[0] = '{pglen: 10'd3, ben4_n: 1'b1, exp_start: 23};
    vecs[1] = '{pglen: 10'd8, ben4_n: 1'b0, exp_start: 38};
    vecs[2] = '{pglen: 10'd8, ben4_n: 1'b1, exp_start: 68};
    vecs[3] = '{pglen: 10'd1, ben4_n: 1'b1, exp_start: 3};
    vecs[4] = '{pglen: 10'd2, ben4_n: 1'b0, exp_start: 8};
    vecs[5] = '{pglen: 10'd5, ben4_n: 1'b0, exp_start: 23};
    vecs[6] = '{pglen: 10'd4, ben4_n: 1'b1, exp_start: 28};

    rst_n = 1'b0;
    pcen_n = 1'b1;
    rot20_n = '1;
    ben4_n = 1'b1;
    sysrun = 1'b1;
    ld = 1'b0;
    pglen = '0;
    xfer = 1'b0;
    end_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset act_n", 32'(act_n), 32'd1);
    chk("reset start_n", 32'(start_n), 32'd1);
    chk("reset done_n", 32'(done_n), 32'd1);
    chk("reset val", 32'(val), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Zero-length page goes straight to SUPB, then async reset lands mid-period.
    rot_pos = 0;
    pglen = '0;
    ld = 1'b1;
    en_cycle();
    ld = 1'b0;
    chk("zero len start_n", 32'(start_n), 32'd0);
    chk("zero len act_n", 32'(act_n), 32'd1);
    en_cycle();
    chk("zero len start one period", 32'(start_n), 32'd1);
    chk("zero len act_n stays high", 32'(act_n), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst act_n", 32'(act_n), 32'd1);
    chk("async rst start_n", 32'(start_n), 32'd1);
    chk("async rst done_n", 32'(done_n), 32'd1);
    chk("async rst val", 32'(val), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    end_n = 1'b0;
    en_cycle();
    en_cycle();
    chk("end ignored after reset", 32'(done_n), 32'd1);
    end_n = 1'b1;

    // Abort mid-MAIN at count 5, with a simultaneous load, END_n and counted bit.
    rot_pos = 0;
    ben4_n = 1'b0;
    xfer = 1'b1;
    pglen = 10'd20;
    ld = 1'b1;
    en_cycle();
    ld = 1'b0;
    for (int unsigned c = 0; c < 200 && val != 10'd5; c++) en_cycle();
    chk("abort reach count 5", 32'(val), 32'd5);
    sysrun = 1'b0;
    ld = 1'b1;
    pglen = 10'd9;
    end_n = 1'b0;
    en_cycle();
    chk("abort act_n", 32'(act_n), 32'd1);
    chk("abort val", 32'(val), 32'd0);
    chk("abort start_n", 32'(start_n), 32'd1);
    chk("abort done_n", 32'(done_n), 32'd1);
    sysrun = 1'b1;
    ld = 1'b0;
    end_n = 1'b1;
    begin
      int unsigned bad = 0;
      repeat (30) begin
        en_cycle();
        if (start_n !== 1'b1 || act_n !== 1'b1 || val !== '0) bad++;
      end
      chk("abort stays idle", bad, 32'd0);
    end

    // Random pages: model counts qualifying slot/bit events against the length.
    for (int t = 0; t < 20; t++) begin
      int unsigned len;
      int unsigned remaining;
      logic b4n;
      len = $urandom_range(1, 30);
      b4n = 1'($urandom_range(0, 1));
      ben4_n = b4n;
      rot_pos = $urandom_range(0, 19);
      pglen = PW'(len);
      xfer = 1'($urandom_range(0, 1));
      ld = 1'b1;
      en_cycle();
      remaining = len;
      chk("rand load act_n", 32'(act_n), 32'd0);
      chk("rand load val", 32'(val), len);
      for (int unsigned c = 0; c < 1500 && remaining != 0; c++) begin
        bit x;
        bit hit;
        x = ($urandom_range(0, 3) != 0);
        xfer = x;
        ld = ($urandom_range(0, 7) == 0);
        pglen = PW'($urandom);
        hit = is_slot(rot_pos, b4n) && x;
        en_cycle();
        if (hit) remaining--;
        chk("rand val", 32'(val), remaining);
        chk("rand act_n", 32'(act_n), (remaining != 0) ? 32'd0 : 32'd1);
        chk("rand start_n", 32'(start_n), (remaining == 0) ? 32'd0 : 32'd1);
      end
      chk("rand page completed", remaining, 32'd0);
      ld = 1'b0;
      end_n = 1'b0;
      en_cycle();
      en_cycle();
      chk("rand page done", 32'(done_n), 32'd0);
      end_n = 1'b1;
      en_cycle();
      chk("rand page done one period", 32'(done_n), 32'd1);
    end

`ifdef BDLCNTR_TIMEOUT_EN
    // SUPB timeout with 4 allowed slot strobes, 2-bit mode: slots at 3,8,23,28.
    begin
      int unsigned tmo_at = 0;
      int unsigned tmo_len = 0;
      int unsigned done_seen = 0;
      rot_pos = 0;
      ben4_n = 1'b1;
      end_n = 1'b1;
      pglen = '0;
      ld = 1'b1;
      en_cycle();
      ld = 1'b0;
      chk("tmo idle value", 32'(tmo_n), 32'd1);
      for (int unsigned c = 1; c <= 40; c++) begin
        en_cycle();
        if (tmo_n === 1'b0) begin
          if (tmo_at == 0) tmo_at = c;
          tmo_len++;
        end
        if (done_n !== 1'b1) done_seen++;
      end
      chk("tmo cycle", tmo_at, 32'd28);
      chk("tmo one period", tmo_len, 32'd1);
      chk("tmo no page done", done_seen, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
